// File: rtl/mpsram_pkg.sv
// Purpose : shared types and helpers for the multi-port SRAM model.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package mpsram_pkg;

    // INIT walks the clear pointer across every entry; READY serves requests.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Byte-lane select: the new byte replaces the old one only when its enable is set.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       mask_bit);
        return mask_bit ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/mpsram_rd_bypass.sv
// Purpose : forwards bytes of not-yet-committed writes onto one read port.
// Latency : combinational.
// Backpr. : none; a pure function of the array word and the write registers.
// Ports   : rd_addr_i  registered read address of this port
//           arr_word_i array content at rd_addr_i
//           wr_*_i     captured write registers of every write port
//           rd_dout_o  forwarded read data
module mpsram_rd_bypass
    import mpsram_pkg::*;
#(
    parameter  int S_INDEX = 4,
    parameter  int WIDTH   = 32,
    parameter  int NUM_WR  = 2,
    parameter  int BYPASS  = 1,
    localparam int MASK_W  = WIDTH / 8
) (
    input  logic [S_INDEX-1:0]             rd_addr_i,
    input  logic [WIDTH-1:0]               arr_word_i,
    input  logic [NUM_WR-1:0]              wr_vld_i,
    input  logic [NUM_WR-1:0][S_INDEX-1:0] wr_addr_i,
    input  logic [NUM_WR-1:0][MASK_W-1:0]  wr_mask_i,
    input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_din_i,
    output logic [WIDTH-1:0]               rd_dout_o
);

    // Ascending port order: a later (higher-index) port overrides earlier ones
    // byte by byte, matching the commit priority of the array.
    always_comb begin
        rd_dout_o = arr_word_i;
        for (int w = 0; w < NUM_WR; w++) begin
            if ((BYPASS != 0) && wr_vld_i[w] && (wr_addr_i[w] == rd_addr_i)) begin
                for (int b = 0; b < MASK_W; b++) begin
                    rd_dout_o[b*8 +: 8] = byte_merge(rd_dout_o[b*8 +: 8],
                                                     wr_din_i[w][b*8 +: 8],
                                                     wr_mask_i[w][b]);
                end
            end
        end
    end

endmodule

// File: rtl/mpsram_fwd.sv
// Purpose : multi-port SRAM model, byte-masked writes, optional write->read bypass, clear FSM.
// Latency : read data one cycle after the request; writes commit one edge after capture.
// Backpr. : ready=0 while clearing; requests presented then are dropped, not stalled.
// Ports   : clk0/rst0_n clock and async active-low reset; init_req re-clears the array;
//           ready high when serving; wr_conflict pulses when >=2 writes hit one address;
//           rd_csb/rd_addr/rd_dout read ports; wr_csb/wr_addr/wr_mask/wr_din write ports.
module mpsram_fwd
    import mpsram_pkg::*;
#(
    parameter  int S_INDEX       = 4,
    parameter  int WIDTH         = 32,
    parameter  int NUM_RD        = 2,
    parameter  int NUM_WR        = 2,
    parameter  int BYPASS        = 1,
    parameter  int INIT_ON_RESET = 1,
    localparam int MASK_W        = WIDTH / 8
) (
    input  logic                           clk0,
    input  logic                           rst0_n,
    input  logic                           init_req,
    output logic                           ready,
    output logic                           wr_conflict,
    input  logic [NUM_RD-1:0]              rd_csb,
    input  logic [NUM_RD-1:0][S_INDEX-1:0] rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rd_dout,
    input  logic [NUM_WR-1:0]              wr_csb,
    input  logic [NUM_WR-1:0][S_INDEX-1:0] wr_addr,
    input  logic [NUM_WR-1:0][MASK_W-1:0]  wr_mask,
    input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_din
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    state_e                         state_q, state_d;
    logic [S_INDEX-1:0]             ptr_q, ptr_d;
    logic [NUM_RD-1:0][S_INDEX-1:0] ra_q, ra_d;
    logic [NUM_WR-1:0]              wv_q, wv_d;
    logic [NUM_WR-1:0][S_INDEX-1:0] wa_q;
    logic [NUM_WR-1:0][MASK_W-1:0]  wm_q;
    logic [NUM_WR-1:0][WIDTH-1:0]   wd_q;
    logic                           conflict_q, conflict_d;
    logic                           cap_en;
    logic [NUM_WR-1:0][WIDTH-1:0]   merged;
    logic [NUM_RD-1:0][WIDTH-1:0]   byp_dout;

    // No reset on the storage: tables are cleared by the FSM, not by reset.
    logic [WIDTH-1:0]               mem_q [NUM_SETS];

    // init_req wins over requests at the same edge, so those requests are dropped.
    assign cap_en = (state_q == READY) && !init_req;

    // ---------------- FSM and clear pointer ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                if (&ptr_q) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + S_INDEX'(1);
                end
            end
            READY: begin
                if (init_req) begin
                    state_d = INIT;
                    ptr_d   = '0;
                end
            end
            default: state_d = READY;
        endcase
    end

    // ---------------- request capture ----------------
    always_comb begin
        ra_d       = ra_q;
        wv_d       = '0;
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (cap_en && !rd_csb[p]) begin
                ra_d[p] = rd_addr[p];
            end
        end
        for (int w = 0; w < NUM_WR; w++) begin
            wv_d[w] = cap_en && !wr_csb[w] && (|wr_mask[w]);
        end
        // Registered alongside the write regs so the pulse lines up with the
        // cycle whose closing edge performs the colliding commit.
        for (int w = 0; w < NUM_WR; w++) begin
            for (int v = w + 1; v < NUM_WR; v++) begin
                if (wv_d[w] && wv_d[v] && (wr_addr[w] == wr_addr[v])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q    <= (INIT_ON_RESET != 0) ? INIT : READY;
            ptr_q      <= '0;
            ra_q       <= '0;
            wv_q       <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ra_q       <= ra_d;
            wv_q       <= wv_d;
            conflict_q <= conflict_d;
        end
    end

    // Payload regs are only meaningful while their valid bit is set.
    always_ff @(posedge clk0) begin
        for (int w = 0; w < NUM_WR; w++) begin
            if (wv_d[w]) begin
                wa_q[w] <= wr_addr[w];
                wm_q[w] <= wr_mask[w];
                wd_q[w] <= wr_din[w];
            end
        end
    end

    // ---------------- write commit ----------------
    // Each port builds the full merged word for its target address, folding in
    // every valid port hitting that address in ascending order. All ports that
    // collide therefore write the identical word, and the highest index wins
    // per byte while lower-port bytes that nobody else touches still land.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            merged[w] = mem_q[wa_q[w]];
            for (int v = 0; v < NUM_WR; v++) begin
                if (wv_q[v] && (wa_q[v] == wa_q[w])) begin
                    for (int b = 0; b < MASK_W; b++) begin
                        merged[w][b*8 +: 8] = byte_merge(merged[w][b*8 +: 8],
                                                         wd_q[v][b*8 +: 8],
                                                         wm_q[v][b]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (state_q == INIT) begin
            mem_q[ptr_q] <= '0;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (wv_q[w]) begin
                mem_q[wa_q[w]] <= merged[w];
            end
        end
    end

    // ---------------- read path ----------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        mpsram_rd_bypass #(
            .S_INDEX (S_INDEX),
            .WIDTH   (WIDTH),
            .NUM_WR  (NUM_WR),
            .BYPASS  (BYPASS)
        ) u_byp (
            .rd_addr_i  (ra_q[p]),
            .arr_word_i (mem_q[ra_q[p]]),
            .wr_vld_i   (wv_q),
            .wr_addr_i  (wa_q),
            .wr_mask_i  (wm_q),
            .wr_din_i   (wd_q),
            .rd_dout_o  (byp_dout[p])
        );
    end

    assign ready       = (state_q == READY);
    assign wr_conflict = conflict_q;
    assign rd_dout     = (state_q == INIT) ? '0 : byp_dout;

endmodule

// File: tb/tb_mpsram_fwd.sv
// Purpose : directed self-checking bench for mpsram_fwd (default parameters).
// Latency : read expectations are queued at issue and checked one cycle later.
// Backpr. : none; waits on ready are bounded.
module tb_mpsram_fwd;

    localparam int S_INDEX  = 4;
    localparam int WIDTH    = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int MASK_W   = WIDTH / 8;
    localparam int NUM_SETS = 2 ** S_INDEX;

    logic                           clk0;
    logic                           rst0_n;
    logic                           init_req;
    logic                           ready;
    logic                           wr_conflict;
    logic [NUM_RD-1:0]              rd_csb;
    logic [NUM_RD-1:0][S_INDEX-1:0] rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0]   rd_dout;
    logic [NUM_WR-1:0]              wr_csb;
    logic [NUM_WR-1:0][S_INDEX-1:0] wr_addr;
    logic [NUM_WR-1:0][MASK_W-1:0]  wr_mask;
    logic [NUM_WR-1:0][WIDTH-1:0]   wr_din;

    mpsram_fwd #(
        .S_INDEX       (S_INDEX),
        .WIDTH         (WIDTH),
        .NUM_RD        (NUM_RD),
        .NUM_WR        (NUM_WR),
        .BYPASS        (1),
        .INIT_ON_RESET (1)
    ) dut (
        .clk0        (clk0),
        .rst0_n      (rst0_n),
        .init_req    (init_req),
        .ready       (ready),
        .wr_conflict (wr_conflict),
        .rd_csb      (rd_csb),
        .rd_addr     (rd_addr),
        .rd_dout     (rd_dout),
        .wr_csb      (wr_csb),
        .wr_addr     (wr_addr),
        .wr_mask     (wr_mask),
        .wr_din      (wr_din)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    typedef struct {
        int          port;
        logic [31:0] val;
        int          id;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      step   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        rd_csb   = '1;
        wr_csb   = '1;
        wr_mask  = '0;
        init_req = 1'b0;
    endtask

    task automatic wr(input int port, input logic [S_INDEX-1:0] addr,
                      input logic [31:0] din, input logic [MASK_W-1:0] mask);
        wr_csb[port]  = 1'b0;
        wr_addr[port] = addr;
        wr_din[port]  = din;
        wr_mask[port] = mask;
    endtask

    task automatic expect_rd(input int port, input logic [31:0] val);
        rd_exp_t e;
        e.port = port;
        e.val  = val;
        e.id   = step;
        step++;
        sb.push_back(e);
    endtask

    task automatic rd(input int port, input logic [S_INDEX-1:0] addr, input logic [31:0] val);
        rd_csb[port]  = 1'b0;
        rd_addr[port] = addr;
        expect_rd(port, val);
    endtask

    task automatic drain();
        rd_exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("rd_p%0d_step%0d", e.port, e.id), rd_dout[e.port], e.val);
        end
    endtask

    // Counts cycles with ready low (including the current one), checking the
    // outputs stay quiet and known; init_req is dropped after 3 cycles so any
    // request held into INIT must be ignored.
    task automatic wait_ready(input string tag);
        int n   = 0;
        bit bad = 1'b0;
        while (ready !== 1'b1 && n < 200) begin
            if ($isunknown(rd_dout) || rd_dout !== '0 || wr_conflict !== 1'b0) bad = 1'b1;
            n++;
            if (n == 3) init_req = 1'b0;
            tick();
        end
        chk({tag, "_cycles"}, 32'(n), 32'(NUM_SETS));
        chk({tag, "_quiet"}, 32'(bad), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst0_n  = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_din  = '0;
        idle();
        tick();
        tick();
        // Reset state
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_conflict", 32'(wr_conflict), 32'h0);
        chk("rst_dout0", rd_dout[0], 32'h0);
        rst0_n = 1'b1;

        // 1. Power-up clear: 16 cycles not ready, then every entry reads zero.
        wait_ready("t1_init");
        for (int a = 0; a < NUM_SETS; a++) begin
            rd(0, S_INDEX'(a), 32'h0);
            rd(1, S_INDEX'(NUM_SETS - 1 - a), 32'h0);
            tick();
            drain();
        end
        idle();

        // 2. Same-cycle write and read: bypass returns new data, then the array holds it.
        wr(0, 4'd3, 32'hDEADBEEF, 4'hF);
        rd(0, 4'd3, 32'hDEADBEEF);
        tick();
        drain();
        idle();
        expect_rd(0, 32'hDEADBEEF);
        tick();
        drain();

        // 3. Write-write collision: byte priority to port 1, conflict pulse for one cycle.
        wr(0, 4'd5, 32'h11111111, 4'hF);
        wr(1, 4'd5, 32'h22222222, 4'h3);
        rd(0, 4'd5, 32'h11112222);
        tick();
        drain();
        chk("t3_conflict_hi", 32'(wr_conflict), 32'h1);
        idle();
        expect_rd(0, 32'h11112222);
        tick();
        drain();
        chk("t3_conflict_lo", 32'(wr_conflict), 32'h0);

        // 4. Held read address follows a later masked write; distinct addresses do not conflict.
        rd(1, 4'd7, 32'h0);
        tick();
        drain();
        idle();
        wr(1, 4'd7, 32'h000000A5, 4'h1);
        wr(0, 4'd8, 32'h12345678, 4'hC);
        expect_rd(1, 32'h000000A5);
        tick();
        drain();
        chk("t4_no_conflict", 32'(wr_conflict), 32'h0);
        idle();
        expect_rd(1, 32'h000000A5);
        tick();
        drain();
        rd(0, 4'd8, 32'h12340000);
        tick();
        drain();
        idle();

        // 5. init_req with a pending write (addr2) and a new request (addr9) at the same edge.
        wr(0, 4'd2, 32'hCAFEF00D, 4'hF);
        rd(0, 4'd2, 32'hCAFEF00D);
        tick();
        drain();
        idle();
        init_req = 1'b1;
        wr(1, 4'd9, 32'h99999999, 4'hF);
        tick();
        idle();
        init_req = 1'b1;
        wait_ready("t5_reinit");
        idle();
        rd(0, 4'd2, 32'h0);
        rd(1, 4'd9, 32'h0);
        tick();
        drain();
        idle();

        // 6. Async reset in the middle of a clear restarts it from entry 0.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (6) tick();
        #2;
        rst0_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(ready), 32'h0);
        chk("t6_rst_conflict", 32'(wr_conflict), 32'h0);
        chk("t6_rst_dout1", rd_dout[1], 32'h0);
        tick();
        rst0_n = 1'b1;
        wait_ready("t6_restart");

        // Post-restart masked write, read back from the array.
        wr(1, 4'd15, 32'hAABBCCDD, 4'h6);
        tick();
        idle();
        rd(1, 4'd15, 32'h00BBCC00);
        tick();
        drain();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
